// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART command path
package uart_pkg;

  typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} asm_state_t;

  localparam int CLK_FREQ_HZ     = 50_000_000;
  localparam int DEF_TIMEOUT_CYC = 500_000;

endpackage

// File: rtl/uart_gap_timer.sv
// rtl/uart_gap_timer.sv - inter-byte gap timer, pulses expired after TIMEOUT_CYC idle cycles
module uart_gap_timer
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] gap_cnt_q, gap_cnt_d;

  // A clear (byte accept) in the same cycle always suppresses expiry.
  assign expired = enable && !clear && (gap_cnt_q == LAST);

  always_comb begin
    gap_cnt_d = gap_cnt_q;
    if (clear || expired) begin
      gap_cnt_d = '0;
    end else if (enable) begin
      gap_cnt_d = gap_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt_q <= '0;
    end else begin
      gap_cnt_q <= gap_cnt_d;
    end
  end

endmodule

// File: rtl/uart_cmd_assembler.sv
// rtl/uart_cmd_assembler.sv - assembles UART_rx bytes (MSB first) into command words
module uart_cmd_assembler
  import uart_pkg::*;
#(
  parameter int NUM_BYTES   = 2,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_rdy,
  input  logic [7:0]             rx_data,
  output logic                   clr_rx_rdy,
  output logic [8*NUM_BYTES-1:0] cmd,
  output logic                   cmd_rdy,
  input  logic                   clr_cmd_rdy,
  output logic                   overrun,
  output logic                   timeout_err
);

  localparam int CW = 8 * NUM_BYTES;
  localparam int BW = $clog2(NUM_BYTES + 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(NUM_BYTES - 1);

  asm_state_t    state_q, state_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;
  logic [CW-1:0] shift_q, shift_d;
  logic [CW-1:0] cmd_q, cmd_d;
  logic          cmd_rdy_q, cmd_rdy_d;
  logic          overrun_q, overrun_d;
  logic          timeout_q, timeout_d;
  logic          accept, complete, expired;

  assign accept   = rx_rdy;
  assign complete = accept && (byte_cnt_q == LAST_BYTE);

  uart_gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_gap_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .enable  (state_q == COLLECT),
    .expired (expired)
  );

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    cmd_d      = cmd_q;
    cmd_rdy_d  = cmd_rdy_q;
    overrun_d  = 1'b0;
    timeout_d  = 1'b0;

    if (clr_cmd_rdy) cmd_rdy_d = 1'b0;

    if (accept) begin
      // Shifting a full-width register means stale bytes fall off the top naturally.
      shift_d = (shift_q << 8) | CW'(rx_data);
      if (complete) begin
        cmd_d      = shift_d;
        cmd_rdy_d  = 1'b1;
        overrun_d  = cmd_rdy_q && !clr_cmd_rdy;
        byte_cnt_d = '0;
        state_d    = IDLE;
      end else begin
        byte_cnt_d = byte_cnt_q + BW'(1);
        state_d    = COLLECT;
      end
    end else if (expired) begin
      byte_cnt_d = '0;
      state_d    = IDLE;
      timeout_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      cmd_q      <= '0;
      cmd_rdy_q  <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      cmd_q      <= cmd_d;
      cmd_rdy_q  <= cmd_rdy_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
    end
  end

  assign clr_rx_rdy  = accept;
  assign cmd         = cmd_q;
  assign cmd_rdy     = cmd_rdy_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// tb/tb_uart_cmd_assembler.sv - scoreboard bench for uart_cmd_assembler
module tb_uart_cmd_assembler;

  localparam int NB = 2;
  localparam int TO = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_cmd_rdy = 1'b0;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        overrun;
  logic        timeout_err;

  uart_cmd_assembler #(.NUM_BYTES(NB), .TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .clr_rx_rdy  (clr_rx_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] cmd;
    logic        ovr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   clr_pulses = 0;
  int   to_pulses = 0;
  int   exp_to = 0;
  int   n_sent = 0;
  logic        prev_rdy = 1'b0;
  logic [15:0] prev_cmd = 16'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    if (rst_n && clr_rx_rdy) clr_pulses++;
  end

  // Monitor: a new command is visible when cmd_rdy rises, overrun pulses, or cmd changes.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (rst_n && timeout_err) to_pulses++;
    if (rst_n && ((cmd_rdy && !prev_rdy) || overrun || (cmd_rdy && cmd != prev_cmd))) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_cmd actual=%0h required=none", cmd);
      end else begin
        e = exp_q.pop_front();
        check("sb_cmd", 32'(cmd), 32'(e.cmd));
        check("sb_overrun", 32'(overrun), 32'(e.ovr));
      end
    end
    prev_rdy = cmd_rdy;
    prev_cmd = cmd;
  end

  task automatic expect_cmd(input logic [15:0] c, input logic ovr);
    exp_t e;
    e.cmd = c;
    e.ovr = ovr;
    exp_q.push_back(e);
  endtask

  // UART_rx model: rdy held until clr_rdy seen at a clock edge.
  task automatic send_byte(input logic [7:0] b, input logic with_clr);
    @(negedge clk);
    rx_data     = b;
    rx_rdy      = 1'b1;
    clr_cmd_rdy = with_clr;
    n_sent++;
    @(posedge clk);
    check("clr_rx_rdy_handshake", 32'(clr_rx_rdy), 32'd1);
    #1;
    rx_rdy      = 1'b0;
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic clear_cmd();
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1;
    clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int n;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_cmd", 32'(cmd), 32'h0);
    check("reset_cmd_rdy", 32'(cmd_rdy), 32'h0);
    check("reset_flags", 32'({overrun, timeout_err, clr_rx_rdy}), 32'h0);

    // 1: basic two-byte command
    c0 = clr_pulses;
    expect_cmd(16'hA53C, 1'b0);
    send_byte(8'hA5, 1'b0);
    check("t1_not_ready_after_first", 32'(cmd_rdy), 32'h0);
    send_byte(8'h3C, 1'b0);
    check("t1_latency_cmd_rdy", 32'(cmd_rdy), 32'h1);
    repeat (3) @(posedge clk);
    check("t1_clr_rx_pulses", 32'(clr_pulses - c0), 32'd2);

    // 2: downstream clear
    clear_cmd();
    check("t2_cmd_rdy_cleared", 32'(cmd_rdy), 32'h0);
    check("t2_cmd_held", 32'(cmd), 32'hA53C);

    // 3: partial command times out
    send_byte(8'h12, 1'b0);
    exp_to++;
    n = 0;
    while (n < TO + 100 && !timeout_err) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t3_timeout_cycles", 32'(n), 32'(TO));
    check("t3_no_cmd_rdy", 32'(cmd_rdy), 32'h0);
    expect_cmd(16'h3456, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0);
    clear_cmd();

    // 4: overrun
    expect_cmd(16'h1122, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    expect_cmd(16'h3344, 1'b1);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    check("t4_cmd_rdy", 32'(cmd_rdy), 32'h1);
    check("t4_cmd", 32'(cmd), 32'h3344);

    // 5: clear coincides with completing byte
    expect_cmd(16'h5566, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b1);
    check("t5_cmd_rdy_stays", 32'(cmd_rdy), 32'h1);
    check("t5_no_overrun", 32'(overrun), 32'h0);
    clear_cmd();

    // 6: reset mid-command
    send_byte(8'h77, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_reset_outputs", 32'({cmd, cmd_rdy, overrun, timeout_err, clr_rx_rdy}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_cmd(16'hBEEF, 1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b0);
    check("t6_cmd", 32'(cmd), 32'hBEEF);

    repeat (TO + 100) @(posedge clk);
    #2;
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);
    check("final_timeouts", 32'(to_pulses), 32'(exp_to));
    check("final_clr_rx_pulses", 32'(clr_pulses), 32'(n_sent));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
